// File: rtl/p1v_rst_pkg.sv
// Shared types for the P1V reset sequencer: FSM state encoding, reset-cause codes
// and the priority encoder that picks the cause on entry to HOLD.
package p1v_rst_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } rst_state_t;

  localparam logic [2:0] CAUSE_POR  = 3'd0;
  localparam logic [2:0] CAUSE_EXT  = 3'd1;
  localparam logic [2:0] CAUSE_SW   = 3'd2;
  localparam logic [2:0] CAUSE_LOCK = 3'd3;
  localparam logic [2:0] CAUSE_WDT  = 3'd4;

  // Simultaneous requests resolve as EXT > SW > LOCK > WDT.
  function automatic logic [2:0] pick_cause(input logic ext_req, input logic sw_req,
                                            input logic lock_lost, input logic wdt_exp);
    if (ext_req)        return CAUSE_EXT;
    else if (sw_req)    return CAUSE_SW;
    else if (lock_lost) return CAUSE_LOCK;
    else if (wdt_exp)   return CAUSE_WDT;
    else                return CAUSE_POR;
  endfunction

endpackage

// File: rtl/p1v_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level; every stage clears to 0 on res.
module p1v_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge res) begin
    if (res) sync_ff <= '0;
    else     sync_ff <= {sync_ff[STAGES-2:0], d};
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/p1v_rst_seq.sv
// P1V reset sequencer: merges pin/software/PLL-lock (and optional watchdog) requests,
// stretches, then releases NUM_DOMAINS active-low resets in stagger order.
// Watchdog is built only when P1V_RST_SEQ_WDT_EN is defined.
module p1v_rst_seq
  import p1v_rst_pkg::*;
#(
  parameter int NUM_DOMAINS    = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDT_CYCLES     = 65536
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   ext_resn,
  input  logic                   sw_res,
  input  logic                   pll_lock,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] nres,
  output logic                   busy,
  output logic [2:0]             cause
);

  localparam int CNT_MAX = ((STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES) - 1;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

  logic ext_sync;
  logic lock_sync;
  logic req;
  logic wdt_exp;
  logic to_hold;

  rst_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] nres_q, nres_d;
  logic [2:0]             cause_q, cause_d;

  p1v_sync_bit #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk (clk),
    .res (res),
    .d   (ext_resn),
    .q   (ext_sync)
  );

  p1v_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .res (res),
    .d   (pll_lock),
    .q   (lock_sync)
  );

  assign req = !ext_sync | sw_res;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      nres_q  <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nres_q  <= nres_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nres_d  = nres_q;
    cause_d = cause_q;
    to_hold = 1'b0;
    case (state_q)
      HOLD: begin
        nres_d = '0;
        if (!req) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (req) begin
          to_hold = 1'b1;
        end else if (lock_sync) begin
          state_d = STRETCH;
          cnt_d   = STRETCH_LOAD;
        end
      end
      // Lock loss here only restarts the lock wait; it is not a reset event.
      STRETCH: begin
        if (req) begin
          to_hold = 1'b1;
        end else if (!lock_sync) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (req || !lock_sync) begin
          to_hold = 1'b1;
        end else if (cnt_q == '0) begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) nres_d[i] = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = STAGGER_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        nres_d = '1;
        if (req || !lock_sync || wdt_exp) to_hold = 1'b1;
      end
      default: to_hold = 1'b1;
    endcase
    // Entering HOLD drops every domain on the same edge and latches the cause.
    if (to_hold) begin
      state_d = HOLD;
      nres_d  = '0;
      cause_d = pick_cause(!ext_sync, sw_res, !lock_sync, wdt_exp);
    end
  end

`ifdef P1V_RST_SEQ_WDT_EN
  localparam logic [31:0] WDT_LOAD = 32'(WDT_CYCLES - 1);

  logic [31:0] wdt_cnt_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wdt_cnt_q <= '0;
    end else if (state_q != RUN) begin
      if (state_d == RUN) wdt_cnt_q <= WDT_LOAD;
    end else if (wdt_kick) begin
      wdt_cnt_q <= WDT_LOAD;
    end else if (wdt_cnt_q != '0) begin
      wdt_cnt_q <= wdt_cnt_q - 1'b1;
    end
  end

  // A kick landing on the zero-count cycle reloads instead of expiring.
  assign wdt_exp = (state_q == RUN) && (wdt_cnt_q == '0) && !wdt_kick;
`else
  logic wdt_unused;
  assign wdt_unused = wdt_kick | (WDT_CYCLES == 0);
  assign wdt_exp    = 1'b0;
`endif

  assign nres  = nres_q;
  assign busy  = (state_q != RUN);
  assign cause = cause_q;

endmodule
